run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter NUM_RST, default 2: number of independent downstream reset channels (1..8).
REQ-002 SHALL have parameter RST_HOLD, default 4: cycles channel 0 stays in reset after start.
REQ-003 SHALL have parameter RST_STAGGER, default 2: extra hold cycles per channel index.
REQ-004 SHALL have parameter TIMEOUT, default 1000: run-cycle limit; 0 disables the timeout.
REQ-005 SHALL have parameter CNT_W, default 32: width of the cycle counter.
REQ-006 SHALL have the following ports:
- clk  in  1  rising-edge clock; the single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse that begins a run sequence.
- halt_valid  in  1  core halt/tohost request.
- halt_code  in  32  tohost value accompanying halt_valid.
- halt_ready  out  1  halt accepted this cycle.
- rst_out  out  NUM_RST  per-channel active-high domain resets.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  run ended with code 1.
- timeout  out  1  run ended by the cycle limit.
- cycle_cnt  out  CNT_W  RUN cycles elapsed.
- exit_code  out  32  latched halt_code.

Function
REQ-007 SHALL implement the FSM IDLE, RESET, RUN, DONE; all outputs registered.
REQ-008 In IDLE, rst_out SHALL be all ones, halt_ready=0, and start SHALL move to RESET next cycle.
REQ-009 On entry to RESET, the hold counter SHALL be 0 and increment each cycle; channel i SHALL deassert on the cycle the counter equals RST_HOLD+i*RST_STAGGER and stay deasserted.
REQ-010 RESET SHALL go to RUN on the cycle after the last channel deasserts; cycle_cnt SHALL be 0 on RUN entry.
REQ-011 In RUN, halt_ready SHALL be 1 and cycle_cnt SHALL increment by 1 per cycle, saturating at all ones.
REQ-012 A RUN cycle with halt_valid=1 SHALL latch exit_code=halt_code and set pass=(halt_code==1); the next state SHALL be DONE.
REQ-013 With TIMEOUT!=0, a RUN cycle with cycle_cnt==TIMEOUT-1 and no halt SHALL set timeout=1, pass=0, and go to DONE.
REQ-014 Halt and timeout in the same cycle: halt SHALL win and timeout SHALL stay 0.
REQ-015 In DONE, rst_out SHALL be all ones, cycle_cnt/exit_code/pass/timeout SHALL hold, and halt_valid SHALL be ignored.
REQ-016 start in DONE SHALL clear pass/timeout/exit_code and enter RESET; start in RESET or RUN SHALL be ignored.
REQ-017 halt_valid outside RUN SHALL have no effect and halt_ready SHALL be 0.

Reset
REQ-018 rst=1 SHALL force IDLE, rst_out all ones, and all other outputs and counters 0 on the next edge, from any state including mid-RESET or mid-RUN.
REQ-019 rst SHALL take priority over start, halt_valid and timeout in the same cycle.

Configuration
REQ-020 With RUN_CTRL_STALL_WDT_EN defined, the block SHALL add the input retire (1 bit), the output stall (1 bit), and the parameter STALL_LIMIT (default 64).
REQ-021 With RUN_CTRL_STALL_WDT_EN defined, if retire stays 0 for STALL_LIMIT consecutive RUN cycles, the block SHALL set stall=1, pass=0, and go to DONE.
REQ-022 Priority SHALL be halt over timeout over stall.
REQ-023 stall SHALL clear on rst or on start from DONE.
REQ-024 Without RUN_CTRL_STALL_WDT_EN, the retire/stall ports and the watchdog logic SHALL be absent.

Verification
REQ-025 Defaults: rst 2 cycles, then start pulse -> rst_out[0] falls 4 cycles after RESET entry, rst_out[1] falls 6 cycles after, and running rises 1 cycle after that.
REQ-026 In RUN, halt_valid with halt_code=1 at cycle_cnt=20 -> done=1, pass=1, exit_code=1, and cycle_cnt holds 20.
REQ-027 In RUN, halt_code=0x2B -> done=1, pass=0, exit_code=0x2B.
REQ-028 TIMEOUT=50, no halt -> timeout=1 with cycle_cnt=49; halt_valid asserted in that same cycle -> pass set and timeout=0.
REQ-029 rst asserted 3 cycles into RUN -> IDLE, all outputs 0 except rst_out=all ones; a following start reruns the full sequence.
REQ-030 With RUN_CTRL_STALL_WDT_EN defined and STALL_LIMIT=8, retire held low -> stall=1 after 8 RUN cycles; a retire pulse every 5 cycles -> no stall.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl: staggered downstream reset release, run supervision (halt / cycle limit) and result reporting.
// Defining RUN_CTRL_STALL_WDT_EN adds the retire/stall ports and a no-retire watchdog (STALL_LIMIT).
module run_ctrl #(
    parameter int unsigned NUM_RST     = 2,
    parameter int unsigned RST_HOLD    = 4,
    parameter int unsigned RST_STAGGER = 2,
    parameter int unsigned TIMEOUT     = 1000,
`ifdef RUN_CTRL_STALL_WDT_EN
    parameter int unsigned STALL_LIMIT = 64,
`endif
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt_valid,
    input  logic [31:0]        halt_code,
`ifdef RUN_CTRL_STALL_WDT_EN
    input  logic               retire,
    output logic               stall,
`endif
    output logic               halt_ready,
    output logic [NUM_RST-1:0] rst_out,
    output logic               running,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [31:0]        exit_code
);
    localparam int unsigned LAST_HOLD = RST_HOLD + (NUM_RST - 1) * RST_STAGGER;
    localparam int unsigned HOLD_W    = (LAST_HOLD < 1) ? 1 : $clog2(LAST_HOLD + 1);

    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_n;
    logic [NUM_RST-1:0] rst_out_n;
    logic               running_n, done_n, pass_n, timeout_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [31:0]        exit_n;
    logic               timeout_hit;

`ifdef RUN_CTRL_STALL_WDT_EN
    localparam int unsigned STALL_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    logic [STALL_W-1:0] idle_cnt, idle_n;
    logic               stall_n, stall_hit;

    // idle_cnt counts earlier consecutive no-retire RUN cycles; this cycle makes STALL_LIMIT.
    assign stall_hit = !retire && (idle_cnt == STALL_W'(STALL_LIMIT - 1));
`endif

    assign timeout_hit = (TIMEOUT != 0) && (cycle_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        // NOTE: every variable gets its default before the case so no path can infer a latch.
        state_n   = state;
        hold_n    = hold_cnt;
        cnt_n     = cycle_cnt;
        exit_n    = exit_code;
        pass_n    = pass;
        timeout_n = timeout;
`ifdef RUN_CTRL_STALL_WDT_EN
        idle_n    = idle_cnt;
        stall_n   = stall;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RESET;
                    hold_n  = '0;
                end
            end
            RESET: begin
                if (hold_cnt == HOLD_W'(LAST_HOLD)) begin
                    state_n = RUN;
                    cnt_n   = '0;
`ifdef RUN_CTRL_STALL_WDT_EN
                    idle_n  = '0;
`endif
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            RUN: begin
                if (halt_valid) begin
                    state_n = DONE;
                    exit_n  = halt_code;
                    pass_n  = (halt_code == 32'd1);
                end else if (timeout_hit) begin
                    state_n   = DONE;
                    timeout_n = 1'b1;
                    pass_n    = 1'b0;
`ifdef RUN_CTRL_STALL_WDT_EN
                end else if (stall_hit) begin
                    state_n = DONE;
                    stall_n = 1'b1;
                    pass_n  = 1'b0;
`endif
                end else begin
                    if (cycle_cnt != '1) cnt_n = cycle_cnt + 1'b1;
`ifdef RUN_CTRL_STALL_WDT_EN
                    idle_n = retire ? '0 : idle_cnt + 1'b1;
`endif
                end
            end
            DONE: begin
                if (start) begin
                    state_n   = RESET;
                    hold_n    = '0;
                    exit_n    = '0;
                    pass_n    = 1'b0;
                    timeout_n = 1'b0;
`ifdef RUN_CTRL_STALL_WDT_EN
                    stall_n   = 1'b0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered from the next state, so they line up with the state they describe.
        rst_out_n = '1;
        for (int unsigned i = 0; i < NUM_RST; i++) begin
            if (state_n == RESET) rst_out_n[i] = 32'(hold_n) < (RST_HOLD + i * RST_STAGGER);
            else                  rst_out_n[i] = (state_n != RUN);
        end
        running_n = (state_n == RUN);
        done_n    = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            rst_out    <= '1;
            running    <= 1'b0;
            halt_ready <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
            exit_code  <= '0;
`ifdef RUN_CTRL_STALL_WDT_EN
            idle_cnt   <= '0;
            stall      <= 1'b0;
`endif
        end else begin
            hold_cnt   <= hold_n;
            rst_out    <= rst_out_n;
            running    <= running_n;
            halt_ready <= running_n;
            done       <= done_n;
            pass       <= pass_n;
            timeout    <= timeout_n;
            cycle_cnt  <= cnt_n;
            exit_code  <= exit_n;
`ifdef RUN_CTRL_STALL_WDT_EN
            idle_cnt   <= idle_n;
            stall      <= stall_n;
`endif
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: vector table, hand-written corner sequences, random run vs reference model.
// Builds with or without RUN_CTRL_STALL_WDT_EN; the watchdog checks only exist when it is defined.
module tb_run_ctrl;
    localparam int unsigned NUM_RST     = 2;
    localparam int unsigned RST_HOLD    = 4;
    localparam int unsigned RST_STAGGER = 2;
    localparam int unsigned TIMEOUT     = 50;
    localparam int unsigned CNT_W       = 32;
    localparam int unsigned LAST_HOLD   = RST_HOLD + (NUM_RST - 1) * RST_STAGGER;
`ifdef RUN_CTRL_STALL_WDT_EN
    localparam int unsigned STALL_LIMIT = 8;
    localparam bit          STALL_EN    = 1'b1;
`else
    localparam int unsigned STALL_LIMIT = 0;
    localparam bit          STALL_EN    = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, halt_valid;
    logic [31:0]        halt_code;
    logic               halt_ready, running, done, pass, timeout;
    logic [NUM_RST-1:0] rst_out;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [31:0]        exit_code;
`ifdef RUN_CTRL_STALL_WDT_EN
    logic               retire, stall, b_stall;
`endif

    // Second instance: zero hold, 3 channels, narrow counter, no timeout.
    logic               b_rst, b_start, b_hv;
    logic               b_halt_ready, b_running, b_done, b_pass, b_timeout;
    logic [2:0]         b_rst_out;
    logic [3:0]         b_cnt;
    logic [31:0]        b_exit;

    run_ctrl #(
        .NUM_RST(NUM_RST), .RST_HOLD(RST_HOLD), .RST_STAGGER(RST_STAGGER), .TIMEOUT(TIMEOUT),
`ifdef RUN_CTRL_STALL_WDT_EN
        .STALL_LIMIT(STALL_LIMIT),
`endif
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halt_valid(halt_valid), .halt_code(halt_code),
`ifdef RUN_CTRL_STALL_WDT_EN
        .retire(retire), .stall(stall),
`endif
        .halt_ready(halt_ready), .rst_out(rst_out), .running(running), .done(done), .pass(pass),
        .timeout(timeout), .cycle_cnt(cycle_cnt), .exit_code(exit_code)
    );

    run_ctrl #(
        .NUM_RST(3), .RST_HOLD(0), .RST_STAGGER(1), .TIMEOUT(0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .halt_valid(b_hv), .halt_code(32'd9),
`ifdef RUN_CTRL_STALL_WDT_EN
        .retire(1'b1), .stall(b_stall),
`endif
        .halt_ready(b_halt_ready), .rst_out(b_rst_out), .running(b_running), .done(b_done),
        .pass(b_pass), .timeout(b_timeout), .cycle_cnt(b_cnt), .exit_code(b_exit)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 reset sequence, 2 run, 3 finished.
    int               m_phase = 0;
    int unsigned      m_k = 0;
    int unsigned      m_idle = 0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic [31:0]      m_exit = '0;
    logic             m_pass = 1'b0, m_to = 1'b0, m_stall = 1'b0;

    function automatic logic [NUM_RST-1:0] m_rst_out();
        logic [NUM_RST-1:0] v;
        for (int unsigned i = 0; i < NUM_RST; i++)
            v[i] = (m_phase == 1) ? (m_k < RST_HOLD + i * RST_STAGGER) : (m_phase != 2);
        return v;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic hv, input logic [31:0] hc,
                              input logic ret);
        if (r) begin
            m_phase = 0; m_k = 0; m_idle = 0; m_cnt = '0; m_exit = '0;
            m_pass = 1'b0; m_to = 1'b0; m_stall = 1'b0;
        end else begin
            case (m_phase)
                0: if (s) begin m_phase = 1; m_k = 0; end
                1: if (m_k == LAST_HOLD) begin m_phase = 2; m_cnt = '0; m_idle = 0; end
                   else m_k++;
                2: if (hv) begin
                       m_exit = hc; m_pass = (hc == 32'd1); m_phase = 3;
                   end else if (TIMEOUT != 0 && m_cnt == CNT_W'(TIMEOUT - 1)) begin
                       m_to = 1'b1; m_pass = 1'b0; m_phase = 3;
                   end else if (STALL_EN && !ret && m_idle + 1 == STALL_LIMIT) begin
                       m_stall = 1'b1; m_pass = 1'b0; m_phase = 3;
                   end else begin
                       if (m_cnt != '1) m_cnt++;
                       m_idle = ret ? 0 : m_idle + 1;
                   end
                3: if (s) begin
                       m_phase = 1; m_k = 0; m_pass = 1'b0; m_to = 1'b0; m_exit = '0; m_stall = 1'b0;
                   end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic hv, input logic [31:0] hc,
                       input logic ret);
        rst = r; start = s; halt_valid = hv; halt_code = hc;
`ifdef RUN_CTRL_STALL_WDT_EN
        retire = ret;
`endif
        model_step(r, s, hv, hc, ret);
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic go_run();
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        repeat (LAST_HOLD + 1) nop();
    endtask

    task automatic chk_vec(input string tag, input logic [NUM_RST-1:0] e_ro, input logic e_run,
                           input logic e_done, input logic e_pass, input logic e_to,
                           input logic [CNT_W-1:0] e_cnt, input logic [31:0] e_exit);
        check({tag, ".rst_out"},    64'(rst_out),    64'(e_ro));
        check({tag, ".running"},    64'(running),    64'(e_run));
        check({tag, ".halt_ready"}, 64'(halt_ready), 64'(e_run));
        check({tag, ".done"},       64'(done),       64'(e_done));
        check({tag, ".pass"},       64'(pass),       64'(e_pass));
        check({tag, ".timeout"},    64'(timeout),    64'(e_to));
        check({tag, ".cycle_cnt"},  64'(cycle_cnt),  64'(e_cnt));
        check({tag, ".exit_code"},  64'(exit_code),  64'(e_exit));
    endtask

    task automatic check_model(input string tag);
        chk_vec(tag, m_rst_out(), m_phase == 2, m_phase == 3, m_pass, m_to, m_cnt, m_exit);
`ifdef RUN_CTRL_STALL_WDT_EN
        check({tag, ".stall"}, 64'(stall), 64'(m_stall));
`endif
    endtask

    typedef struct {
        logic r, s, hv;
        logic [31:0] hc;
        logic [NUM_RST-1:0] e_ro;
        logic e_run, e_done, e_pass, e_to;
        logic [CNT_W-1:0] e_cnt;
        logic [31:0] e_exit;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic hv, input logic [31:0] hc,
                                input logic [NUM_RST-1:0] ro, input logic run,
                                input logic [CNT_W-1:0] cnt);
        vec_t v;
        v.r = r; v.s = s; v.hv = hv; v.hc = hc; v.e_ro = ro; v.e_run = run;
        v.e_done = 1'b0; v.e_pass = 1'b0; v.e_to = 1'b0; v.e_cnt = cnt; v.e_exit = '0;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        b_rst = 1'b1; b_start = 1'b0; b_hv = 1'b0;

        // Narrow instance: immediate channel-0 release, counter saturation, no timeout.
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        check("b.reset.rst_out", 64'(b_rst_out), 64'h7);
        check("b.reset.cnt", 64'(b_cnt), 64'h0);
        b_rst = 1'b0; b_start = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        b_start = 1'b0;
        check("b.k0.rst_out", 64'(b_rst_out), 64'h6);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        check("b.k1.rst_out", 64'(b_rst_out), 64'h4);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        check("b.k2.rst_out", 64'(b_rst_out), 64'h0);
        check("b.k2.running", 64'(b_running), 64'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        check("b.run.running", 64'(b_running), 64'h1);
        check("b.run.halt_ready", 64'(b_halt_ready), 64'h1);
        check("b.run.cnt", 64'(b_cnt), 64'h0);
        repeat (15) cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        check("b.cnt15", 64'(b_cnt), 64'd15);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        check("b.sat.cnt", 64'(b_cnt), 64'd15);
        check("b.sat.timeout", 64'(b_timeout), 64'h0);
        check("b.sat.running", 64'(b_running), 64'h1);
        b_hv = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        b_hv = 1'b0;
        check("b.halt.done", 64'(b_done), 64'h1);
        check("b.halt.pass", 64'(b_pass), 64'h0);
        check("b.halt.exit", 64'(b_exit), 64'd9);
        check("b.halt.cnt", 64'(b_cnt), 64'd15);
        b_rst = 1'b1;

        // Power-up and staggered release with default hold/stagger.
        tbl.push_back(mk(1, 0, 0, 32'd0, 2'b11, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'd1, 2'b11, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'd1, 2'b11, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'd0, 2'b11, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'd1, 2'b11, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'd0, 2'b11, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 2'b11, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 2'b10, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 2'b10, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 2'b00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 32'd0, 2'b00, 1, 1));
        tbl.push_back(mk(0, 0, 0, 32'd0, 2'b00, 1, 2));
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].hv, tbl[i].hc, 1'b1);
            chk_vec($sformatf("tbl%0d", i), tbl[i].e_ro, tbl[i].e_run, tbl[i].e_done,
                    tbl[i].e_pass, tbl[i].e_to, tbl[i].e_cnt, tbl[i].e_exit);
        end

        // Pass halt at cycle 20; later halts in DONE are ignored.
        repeat (18) nop();
        chk_vec("run20", 2'b00, 1, 0, 0, 0, 20, 0);
        cyc(1'b0, 1'b0, 1'b1, 32'd1, 1'b1);
        chk_vec("halt_pass", 2'b11, 0, 1, 1, 0, 20, 1);
        cyc(1'b0, 1'b0, 1'b1, 32'd7, 1'b1);
        chk_vec("done_ignores_halt", 2'b11, 0, 1, 1, 0, 20, 1);

        // Restart from DONE clears the result; fail code 0x2B.
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk_vec("restart", 2'b11, 0, 0, 0, 0, 20, 0);
        repeat (LAST_HOLD) nop();
        chk_vec("hold_end", 2'b00, 0, 0, 0, 0, 20, 0);
        nop();
        chk_vec("run_entry", 2'b00, 1, 0, 0, 0, 0, 0);
        repeat (3) nop();
        cyc(1'b0, 1'b0, 1'b1, 32'h2B, 1'b1);
        chk_vec("halt_fail", 2'b11, 0, 1, 0, 0, 3, 32'h2B);

        // Cycle limit, then halt colliding with the limit.
        go_run();
        repeat (TIMEOUT - 1) nop();
        chk_vec("cnt49", 2'b00, 1, 0, 0, 0, 49, 0);
        nop();
        chk_vec("timeout", 2'b11, 0, 1, 0, 1, 49, 0);
        cyc(1'b0, 1'b0, 1'b1, 32'd1, 1'b1);
        chk_vec("timeout_hold", 2'b11, 0, 1, 0, 1, 49, 0);
        go_run();
        repeat (TIMEOUT - 1) nop();
        cyc(1'b0, 1'b0, 1'b1, 32'd1, 1'b1);
        chk_vec("halt_beats_timeout", 2'b11, 0, 1, 1, 0, 49, 1);

        // Reset mid-RUN and mid-RESET, then a full rerun.
        go_run();
        repeat (3) nop();
        chk_vec("run3", 2'b00, 1, 0, 0, 0, 3, 0);
        cyc(1'b1, 1'b1, 1'b1, 32'd1, 1'b1);
        chk_vec("rst_in_run", 2'b11, 0, 0, 0, 0, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        nop(); nop();
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_vec("rst_in_reset", 2'b11, 0, 0, 0, 0, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        repeat (4) nop();
        chk_vec("rerun_k4", 2'b10, 0, 0, 0, 0, 0, 0);
        repeat (2) nop();
        chk_vec("rerun_k6", 2'b00, 0, 0, 0, 0, 0, 0);
        nop();
        chk_vec("rerun_run", 2'b00, 1, 0, 0, 0, 0, 0);

`ifdef RUN_CTRL_STALL_WDT_EN
        // Watchdog: retire held low trips after STALL_LIMIT RUN cycles; periodic retire keeps it quiet.
        repeat (STALL_LIMIT - 1) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        check("stall_pre", 64'(stall), 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk_vec("stall_trip", 2'b11, 0, 1, 0, 0, STALL_LIMIT - 1, 0);
        check("stall_trip.stall", 64'(stall), 64'h1);
        go_run();
        check("stall_cleared", 64'(stall), 64'h0);
        for (int n = 0; n < 40; n++) cyc(1'b0, 1'b0, 1'b0, 32'd0, (n % 5) == 4);
        chk_vec("retire_5", 2'b00, 1, 0, 0, 0, 40, 0);
        check("retire_5.stall", 64'(stall), 64'h0);
`endif

        // Random traffic against the reference model.
        begin
            logic bursty = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                logic r, s, hv, ret;
                logic [31:0] hc;
                int sel;
                if ($urandom_range(0, 15) == 0) bursty = ~bursty;
                r   = ($urandom_range(0, 99) < 2);
                s   = ($urandom_range(0, 9) < 2);
                hv  = ($urandom_range(0, 99) < 4);
                sel = $urandom_range(0, 2);
                hc  = (sel == 0) ? 32'd1 : (sel == 1) ? 32'd0 : $urandom;
                ret = bursty ? 1'b0 : ($urandom_range(0, 3) != 0);
                cyc(r, s, hv, hc, ret);
                check_model($sformatf("rand%0d", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
